hazard_ctrl_unit: RTL

//  Parametrised pipeline-control unit for the 5-stage MIPS core. It replaces the stall-only scheme with:
//   - operand forwarding and load-use detection
//   - a counter-based branch flush sized by the branch-resolution stage
//   - data/instruction memory wait-state freezing
//   - debug single-step and stall/flush performance counters

---
 rtl/hazard_ctrl_unit_pkg.sv | 15 +
 rtl/hazard_ctrl_unit_hazard_detect.sv | 54 +++++
 rtl/hazard_ctrl_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
//   FWD_REG/FWD_EXE/FWD_MEM : operand-forward mux encodings driven onto fwd_*_sel
//   state_t                 : control FSM states (RUN = normal issue, FLUSH = branch bubbles pending)
package hazard_ctrl_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_unit_hazard_detect.sv
// Per-operand RAW hazard compare for one ID source register (pure combinational).
// Ports:
//   i_src_addr / i_src_used      : ID source register and whether it is read
//   i_exe_wb_addr / i_exe_wb_wen : EXE destination and write enable
//   i_exe_mem_ren                : EXE instruction is a load (result not ready yet)
//   i_mem_wb_addr / i_mem_wb_wen : MEM destination and write enable
//   o_fwd_sel                    : FWD_REG / FWD_EXE / FWD_MEM
//   o_stall                      : operand cannot be satisfied this cycle
module hazard_ctrl_unit_hazard_detect
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1
) (
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic                  i_src_used,
    input  logic [REG_ADDR_W-1:0] i_exe_wb_addr,
    input  logic                  i_exe_wb_wen,
    input  logic                  i_exe_mem_ren,
    input  logic [REG_ADDR_W-1:0] i_mem_wb_addr,
    input  logic                  i_mem_wb_wen,
    output logic [1:0]            o_fwd_sel,
    output logic                  o_stall
);

    logic w_live;
    logic w_exe_hit;
    logic w_mem_hit;

    // r0 is hard-wired zero, so it never creates a dependency.
    assign w_live    = i_src_used && (i_src_addr != '0);
    assign w_exe_hit = w_live && i_exe_wb_wen && (i_src_addr == i_exe_wb_addr);
    assign w_mem_hit = w_live && i_mem_wb_wen && (i_src_addr == i_mem_wb_addr);

    // The younger (EXE) producer wins over MEM; a load in EXE has no data yet.
    always_comb begin
        o_fwd_sel = FWD_REG;
        o_stall   = 1'b0;
        if (w_exe_hit) begin
            if ((FWD_EN != 0) && !i_exe_mem_ren) begin
                o_fwd_sel = FWD_EXE;
            end else begin
                o_stall = 1'b1;
            end
        end else if (w_mem_hit) begin
            if (FWD_EN != 0) begin
                o_fwd_sel = FWD_MEM;
            end else begin
                o_stall = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline control unit for the 5-stage MIPS core: operand forwarding, load-use /
// RAW stalls, counter-based branch flush, memory wait-state freeze, debug single
// step and saturating stall/flush performance counters.
// Ports:
//   clk, rst (sync, active-high)
//   debug_en, debug_step             : debug freeze and single-step request
//   id_rs_*/id_rt_*, id_is_branch    : ID stage operand use and PC-altering flag
//   exe_wb_*, exe_mem_ren, mem_wb_*  : producers in EXE and MEM
//   imem_ack, dmem_req, dmem_ack     : memory handshakes
//   {if,id,exe,mem,wb}_{rst,en}      : stage register strobes
//   fwd_a_sel, fwd_b_sel             : EXE operand-forward mux selects
//   perf_stall_cnt, perf_flush_cnt   : saturating performance counters
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FWD_EN       = 1,
    parameter int BRANCH_STAGE = 2,
    parameter int PERF_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_en,
    input  logic                  debug_step,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic                  id_rs_used,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_rt_used,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] exe_wb_addr,
    input  logic                  exe_wb_wen,
    input  logic                  exe_mem_ren,
    input  logic [REG_ADDR_W-1:0] mem_wb_addr,
    input  logic                  mem_wb_wen,
    input  logic                  imem_ack,
    input  logic                  dmem_req,
    input  logic                  dmem_ack,
    output logic                  if_rst,
    output logic                  if_en,
    output logic                  id_rst,
    output logic                  id_en,
    output logic                  exe_rst,
    output logic                  exe_en,
    output logic                  mem_rst,
    output logic                  mem_en,
    output logic                  wb_rst,
    output logic                  wb_en,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [PERF_W-1:0]     perf_stall_cnt,
    output logic [PERF_W-1:0]     perf_flush_cnt
);

    // Bubbles still owed after the branch cycle itself: BRANCH_STAGE-1.
    localparam int CNT_W = (BRANCH_STAGE > 1) ? $clog2(BRANCH_STAGE) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(BRANCH_STAGE - 1);

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : (v + PERF_W'(1));
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             r_step_prev;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_perf;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_flush_cnt_nxt;
    logic [1:0]       w_rs_sel;
    logic [1:0]       w_rt_sel;
    logic             w_rs_stall;
    logic             w_rt_stall;
    logic             w_raw_stall;
    logic             w_step_edge;
    logic             w_dmem_wait;
    logic             w_dbg_freeze;
    logic             w_imem_wait;
    logic             w_advance;
    logic             w_stall_act;
    logic             w_flush_act;

    hazard_ctrl_unit_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_hd_rs (
        .i_src_addr    (id_rs_addr),
        .i_src_used    (id_rs_used),
        .i_exe_wb_addr (exe_wb_addr),
        .i_exe_wb_wen  (exe_wb_wen),
        .i_exe_mem_ren (exe_mem_ren),
        .i_mem_wb_addr (mem_wb_addr),
        .i_mem_wb_wen  (mem_wb_wen),
        .o_fwd_sel     (w_rs_sel),
        .o_stall       (w_rs_stall)
    );

    hazard_ctrl_unit_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_hd_rt (
        .i_src_addr    (id_rt_addr),
        .i_src_used    (id_rt_used),
        .i_exe_wb_addr (exe_wb_addr),
        .i_exe_wb_wen  (exe_wb_wen),
        .i_exe_mem_ren (exe_mem_ren),
        .i_mem_wb_addr (mem_wb_addr),
        .i_mem_wb_wen  (mem_wb_wen),
        .o_fwd_sel     (w_rt_sel),
        .o_stall       (w_rt_stall)
    );

    assign w_raw_stall  = w_rs_stall | w_rt_stall;
    assign w_step_edge  = debug_step & ~r_step_prev;
    assign w_dmem_wait  = dmem_req & ~dmem_ack;
    assign w_dbg_freeze = debug_en & ~w_step_edge;
    assign w_imem_wait  = ~imem_ack;
    assign w_advance    = ~w_dmem_wait & ~w_dbg_freeze & ~w_imem_wait;

    // A stall or flush only "wins" when nothing of higher priority is freezing
    // the pipe; these qualified strobes drive both the FSM and the counters.
    assign w_stall_act  = w_advance & w_raw_stall;
    assign w_flush_act  = w_advance & ~w_raw_stall & ((r_state == FLUSH) | id_is_branch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_cnt  <= '0;
            r_step_prev  <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_perf <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_step_prev <= debug_step;
            if (w_stall_act) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_act) begin
                r_flush_perf <= sat_inc(r_flush_perf);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        if_rst    = 1'b0;
        if_en     = 1'b1;
        id_rst    = 1'b0;
        id_en     = 1'b1;
        exe_rst   = 1'b0;
        exe_en    = 1'b1;
        mem_rst   = 1'b0;
        mem_en    = 1'b1;
        wb_rst    = 1'b0;
        wb_en     = 1'b1;
        fwd_a_sel = w_rs_sel;
        fwd_b_sel = w_rt_sel;

        // The branch cycle itself is the first bubble; FLUSH covers the rest.
        case (r_state)
            RUN: begin
                if (w_flush_act && (BRANCH_STAGE > 1)) begin
                    w_state_nxt     = FLUSH;
                    w_flush_cnt_nxt = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (w_flush_act) begin
                    if (r_flush_cnt <= CNT_W'(1)) begin
                        w_state_nxt     = RUN;
                        w_flush_cnt_nxt = '0;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase

        // Strobe priority: reset, dmem wait, debug freeze, imem wait, RAW, flush.
        if (rst) begin
            if_rst    = 1'b1;
            id_rst    = 1'b1;
            exe_rst   = 1'b1;
            mem_rst   = 1'b1;
            wb_rst    = 1'b1;
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
        end else if (w_dmem_wait) begin
            // Hold IF..MEM; WB gets a bubble so the stalled access is not retired twice.
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
            wb_rst = 1'b1;
        end else if (w_dbg_freeze) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (w_imem_wait) begin
            if_en  = 1'b0;
            id_rst = 1'b1;
        end else if (w_raw_stall) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else if (w_flush_act) begin
            id_rst = 1'b1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_perf;

endmodule
